// File: rtl/mips_mem_pkg.sv
// Purpose: shared types and widths for the MIPS memory stage and its data memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int WORD_W        = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int DEFAULT_DEPTH = 256;

    // Multi-cycle access sequencer states (used only when MEM_STALL_EN is defined).
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // MEM/WB pipeline latch contents.
    typedef struct packed {
        logic [WORD_W-1:0]     alu_result;
        logic [WORD_W-1:0]     read_data;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  memtoreg;
        logic                  regwrite;
    } memwb_t;

endpackage

// File: rtl/data_memory.sv
// Purpose: DEPTH x 32-bit word-addressed data memory, contents survive reset.
// Latency: read is combinational; write lands on the rising edge when we is high.
// Backpressure: none, always ready.
// Ports: clk; we (write enable); addr (word index); wdata (store data); rdata (word at addr).
module data_memory
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: MIPS MEM stage: load/store against data_memory and the MEM/WB latch.
// Latency: 1 cycle; LATENCY cycles per load/store when MEM_STALL_EN is defined.
// Backpressure: with MEM_STALL_EN, registered stall asks upstream to hold EX/MEM inputs.
// Ports: clk, rst (sync, active high); ex_* EX/MEM inputs (address/ALU result, store data,
//        dest reg, memread, memwrite, memtoreg, regwrite); mem_* / memtoreg / regwrite
//        MEM/WB latch outputs; stall to the hazard unit.
// Build option: define MEM_STALL_EN for the multi-cycle memory model.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     ex_alu_result,
    input  logic [WORD_W-1:0]     ex_write_data,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  ex_memread,
    input  logic                  ex_memwrite,
    input  logic                  ex_memtoreg,
    input  logic                  ex_regwrite,
    output logic [WORD_W-1:0]     mem_alu_result,
    output logic [WORD_W-1:0]     mem_read_data,
    output logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic                  memtoreg,
    output logic                  regwrite,
    output logic                  stall
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_access_stage: DEPTH must be a power of two");
    end
    if (LATENCY < 2) begin : g_bad_latency
        $error("mem_access_stage: LATENCY must be at least 2");
    end

    // Byte address -> word index: low two bits and bits above the array drop out,
    // so unaligned accesses hit the containing word and addresses wrap.
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] rd_data;
    logic              we_c;
    memwb_t            real_c;
    memwb_t            nxt;
    memwb_t            q;

    assign word_idx = ex_alu_result[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ex_alu_result[WORD_W-1:AW+2], ex_alu_result[1:0]};

    // rd_data is the pre-store word, so a combined read+write reports the old contents.
    assign real_c = '{
        alu_result: ex_alu_result,
        read_data:  rd_data,
        write_reg:  ex_write_reg,
        memtoreg:   ex_memtoreg,
        regwrite:   ex_regwrite
    };

`ifdef MEM_STALL_EN
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             mem_op;

    assign mem_op = ex_memread | ex_memwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Bubbles (all-zero latch) are sent down while the access is in flight; the real
    // values and the store commit happen together on the last BUSY cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        nxt     = '0;
        we_c    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_n = BUSY;
                    cnt_n   = CNT_W'(LATENCY - 2);
                end else begin
                    nxt = real_c;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    nxt     = real_c;
                    we_c    = ex_memwrite;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Driven straight from the state register, never from the inputs.
    assign stall = (state == BUSY);
`else
    always_comb begin
        nxt  = real_c;
        we_c = ex_memwrite;
    end

    assign stall = 1'b0;

    logic unused_memread;
    assign unused_memread = ex_memread;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

    // A store in flight when reset arrives must not land.
    data_memory #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (we_c & ~rst),
        .addr  (word_idx),
        .wdata (ex_write_data),
        .rdata (rd_data)
    );

    assign mem_alu_result = q.alu_result;
    assign mem_read_data  = q.read_data;
    assign mem_write_reg  = q.write_reg;
    assign memtoreg       = q.memtoreg;
    assign regwrite       = q.regwrite;

endmodule
